// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, port indices and state encoding for the RAM arbiter
package mem_arb_pkg;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int PORT_CPU  = 0;
  localparam int PORT_HOST = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: two-requester picker with lock filtering and fixed or round-robin tie-break
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_fixed_prio,
  input  logic       i_lock_owner,
  input  logic       i_lock_valid,
  output logic [1:0] o_win
);
  logic [1:0] w_owner;
  logic [1:0] w_elig;
  logic       w_tie;
  assign w_owner = i_lock_owner ? 2'b10 : 2'b01;
  assign w_elig  = i_lock_valid ? (i_req & w_owner) : i_req;
  assign w_tie   = i_fixed_prio ? 1'(PORT_CPU) : i_ptr;
  assign o_win   = (&w_elig) ? (w_tie ? 2'b10 : 2'b01) : w_elig;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two request/grant ports onto one synchronous RAM
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter bit FIXED_PRIO  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_we,
  input  logic [1:0]        i_lock,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic [1:0]        o_gnt,
  output logic [1:0]        o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_wren,
  input  logic [DATA_W-1:0] i_ram_q
);
  state_t     r_state;
  logic       r_ptr;
  logic       r_lock_valid;
  logic       r_lock_owner;
  logic       r_port;
  logic [1:0] r_cnt;
  logic [1:0] w_win;
  logic       w_sel;
  arb_pick u_pick (
    .i_req        (i_req),
    .i_ptr        (r_ptr),
    .i_fixed_prio (FIXED_PRIO),
    .i_lock_owner (r_lock_owner),
    .i_lock_valid (r_lock_valid),
    .o_win        (w_win)
  );
  assign o_gnt  = (i_reset_n && r_state == ST_IDLE) ? w_win : 2'b00;
  assign w_sel  = o_gnt[PORT_HOST];
  assign o_busy = r_state != ST_IDLE;
  // r_ptr names the port that wins the next tie, i.e. the one not granted last
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 1'b0;
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
      r_port       <= 1'b0;
      r_cnt        <= 2'd0;
      o_ram_addr   <= '0;
      o_ram_data   <= '0;
      o_ram_wren   <= 1'b0;
      o_rdata      <= '0;
      o_rvalid     <= 2'b00;
    end else begin
      o_rvalid <= 2'b00;
      case (r_state)
        ST_IDLE: if (|o_gnt) begin
          r_state      <= ST_ACCESS;
          r_port       <= w_sel;
          r_ptr        <= ~w_sel;
          r_lock_valid <= i_lock[w_sel];
          r_lock_owner <= w_sel;
          o_ram_addr   <= w_sel ? i_addr1 : i_addr0;
          o_ram_data   <= w_sel ? i_wdata1 : i_wdata0;
          o_ram_wren   <= i_we[w_sel];
        end
        ST_ACCESS: begin
          o_ram_wren <= 1'b0;
          r_cnt      <= 2'(RAM_LATENCY - 1);
          r_state    <= o_ram_wren ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: if (r_cnt == 2'd0) begin
          r_state  <= ST_IDLE;
          o_rdata  <= i_ram_q;
          o_rvalid <= r_port ? 2'b10 : 2'b01;
        end else begin
          r_cnt <= r_cnt - 2'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiter variants (RR/L1, fixed/L1, RR/L3) sharing one stimulus
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00, we = 2'b00, lock = 2'b00;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wd0 = 8'h00, wd1 = 8'h00;
  logic [1:0] gnt [3];
  logic [1:0] rvalid [3];
  logic [7:0] rdata [3];
  logic       busy [3];
  logic [7:0] ram_addr [3];
  logic [7:0] ram_data [3];
  logic       wren [3];
  logic [7:0] ram_q [3];
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LAT = (g == 2) ? 3 : 1;
    logic [7:0] mem [256] = '{255: 8'h3C, default: 8'h00};
    logic [7:0] pipe [3];
    mem_arbiter #(.RAM_LATENCY(LAT), .FIXED_PRIO(g == 1)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_we(we), .i_lock(lock),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wd0), .i_wdata1(wd1),
      .o_gnt(gnt[g]), .o_rvalid(rvalid[g]), .o_rdata(rdata[g]), .o_busy(busy[g]),
      .o_ram_addr(ram_addr[g]), .o_ram_data(ram_data[g]), .o_ram_wren(wren[g]),
      .i_ram_q(ram_q[g])
    );
    always @(posedge clk) begin
      if (wren[g]) mem[ram_addr[g]] <= ram_data[g];
      pipe[0] <= mem[ram_addr[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ram_q[g] = pipe[LAT-1];
  end
  typedef struct {
    logic [1:0] req, we;
    logic [7:0] a0, a1, d0;
    logic [1:0] gnt;
    logic       wren, busy;
    logic [1:0] rv;
    logic [7:0] rd, ra;
  } vec_t;
  vec_t tv [7];
  int ng, nw, n0, n1, k, bcnt, rv0_t, rv2_t;
  logic [7:0] seq, rd0, rd2;
  logic [1:0] rvv;
  logic [1:0] q0 [4];
  logic [1:0] q1 [4];
  logic [1:0] exp_rr [4];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    req = 2'b00;
    lock = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    nxt();
  endtask
  initial begin
    tv[0] = '{2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 2'b01, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00};
    tv[1] = '{2'b10, 2'b00, 8'h10, 8'h10, 8'hA5, 2'b00, 1'b1, 1'b1, 2'b00, 8'h00, 8'h10};
    tv[2] = '{2'b10, 2'b00, 8'h10, 8'h10, 8'hA5, 2'b10, 1'b0, 1'b0, 2'b00, 8'h00, 8'h10};
    tv[3] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 2'b00, 8'h00, 8'h10};
    tv[4] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 2'b00, 8'h00, 8'h10};
    tv[5] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b10, 8'hA5, 8'h10};
    tv[6] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'hA5, 8'h10};
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
    req = 2'b11;
    #2;
    chk("rst gnt", gnt[0], 2'b00);
    chk("rst busy", busy[0], 1'b0);
    chk("rst rvalid", rvalid[0], 2'b00);
    chk("rst rdata", rdata[0], 8'h00);
    chk("rst ram_addr", ram_addr[0], 8'h00);
    chk("rst wren", wren[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b00;
    nxt();
    // write then read-back, checked on both latency-1 variants
    for (int i = 0; i < 7; i++) begin
      req = tv[i].req; we = tv[i].we; addr0 = tv[i].a0; addr1 = tv[i].a1; wd0 = tv[i].d0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("v%0d.d%0d gnt", i, d), gnt[d], tv[i].gnt);
        chk($sformatf("v%0d.d%0d wren", i, d), wren[d], tv[i].wren);
        chk($sformatf("v%0d.d%0d busy", i, d), busy[d], tv[i].busy);
        chk($sformatf("v%0d.d%0d rvalid", i, d), rvalid[d], tv[i].rv);
        chk($sformatf("v%0d.d%0d rdata", i, d), rdata[d], tv[i].rd);
        chk($sformatf("v%0d.d%0d ram_addr", i, d), ram_addr[d], tv[i].ra);
      end
      nxt();
    end
    // continuous reads from both ports
    do_reset();
    req = 2'b11; we = 2'b00; addr0 = 8'h01; addr1 = 8'h02;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt[0] != 2'b00 && n0 < 4) begin q0[n0] = gnt[0]; n0++; end
      if (gnt[1] != 2'b00 && n1 < 4) begin q1[n1] = gnt[1]; n1++; end
      nxt();
    end
    chk("rr count", n0, 4);
    chk("fixed count", n1, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr gnt%0d", i), q0[i], exp_rr[i]);
      chk($sformatf("fixed gnt%0d", i), q1[i], 2'b01);
    end
    // locked burst from port 1 while port 0 keeps requesting
    do_reset();
    k = 0; seq = 8'h00; n0 = 0;
    for (int c = 0; c < 30 && n0 < 4; c++) begin
      req = {k < 3, c > 0}; we = 2'b10; lock = {k < 2, 1'b0};
      addr1 = 8'h20 + 8'(k); wd1 = 8'h50 + 8'(k); addr0 = 8'h30;
      @(negedge clk);
      if (gnt[0] != 2'b00) begin seq = {seq[5:0], gnt[0]}; n0++; end
      if (gnt[0] == 2'b10) k++;
      nxt();
    end
    chk("lock seq", seq, 8'hA9);
    chk("lock mem20", u[0].mem[8'h20], 8'h50);
    chk("lock mem21", u[0].mem[8'h21], 8'h51);
    chk("lock mem22", u[0].mem[8'h22], 8'h52);
    // latency-3 read of a preloaded location
    do_reset();
    req = 2'b01; we = 2'b00; addr0 = 8'hFF;
    @(negedge clk);
    chk("l3 gnt", gnt[2], 2'b01);
    nxt();
    req = 2'b00;
    rv0_t = -1; rv2_t = -1; bcnt = 0; rd0 = 8'h00; rd2 = 8'h00; rvv = 2'b00;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      bcnt += int'(busy[2]);
      if (rvalid[2] != 2'b00 && rv2_t < 0) begin rv2_t = t; rd2 = rdata[2]; rvv = rvalid[2]; end
      if (rvalid[0] != 2'b00 && rv0_t < 0) begin rv0_t = t; rd0 = rdata[0]; end
      nxt();
    end
    chk("l3 rvalid time", rv2_t, 5);
    chk("l3 rvalid port", rvv, 2'b01);
    chk("l3 rdata", rd2, 8'h3C);
    chk("l3 busy cycles", bcnt, 4);
    chk("l1 rvalid time", rv0_t, 3);
    chk("l1 rdata", rd0, 8'h3C);
    // asynchronous reset while a read waits for the RAM
    do_reset();
    req = 2'b01; we = 2'b00; addr0 = 8'hFF;
    nxt();
    req = 2'b00;
    nxt();
    @(negedge clk);
    chk("abort pre busy", busy[2], 1'b1);
    chk("abort pre addr", ram_addr[2], 8'hFF);
    #1 rst_n = 1'b0; req = 2'b11;
    #1;
    chk("abort busy", busy[2], 1'b0);
    chk("abort addr", ram_addr[2], 8'h00);
    chk("abort gnt", gnt[0], 2'b00);
    @(negedge clk);
    req = 2'b00;
    rst_n = 1'b1;
    nw = 0;
    for (int t = 0; t < 6; t++) begin
      nxt();
      @(negedge clk);
      if (rvalid[2] != 2'b00) nw++;
    end
    chk("abort no rvalid", nw, 0);
    // asynchronous reset during a write ACCESS
    nxt();
    req = 2'b01; we = 2'b01; addr0 = 8'h40; wd0 = 8'h77;
    @(negedge clk);
    chk("wabort gnt", gnt[0], 2'b01);
    nxt();
    req = 2'b00;
    @(negedge clk);
    chk("wabort pre wren", wren[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("wabort wren", wren[0], 1'b0);
    chk("wabort data", ram_data[0], 8'h00);
    req = 2'b11; we = 2'b00;
    @(negedge clk);
    chk("wabort mem", u[0].mem[8'h40], 8'h00);
    rst_n = 1'b1;
    #1;
    chk("post reset tie", gnt[0], 2'b01);
    // short-lived request during a busy cycle
    do_reset();
    req = 2'b10; we = 2'b10; addr1 = 8'h66; wd1 = 8'h11;
    @(negedge clk);
    chk("cancel host gnt", gnt[0], 2'b10);
    nxt();
    req = 2'b01; we = 2'b01; addr0 = 8'h77; wd0 = 8'h22;
    @(negedge clk);
    chk("cancel busy gnt", gnt[0], 2'b00);
    nxt();
    req = 2'b00;
    ng = 0; nw = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (gnt[0] != 2'b00) ng++;
      if (wren[0]) nw++;
      nxt();
    end
    chk("cancel grants", ng, 0);
    chk("cancel wren", nw, 0);
    chk("cancel ram_addr", ram_addr[0], 8'h66);
    chk("cancel mem77", u[0].mem[8'h77], 8'h00);
    chk("cancel mem66", u[0].mem[8'h66], 8'h11);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
